// File: rtl/chainreset_sequencer.sv
// Sequencer that kicks a chainreset, follows its steps and retries a failing step
// after a holdoff, giving up once a step has used all of its retries.
//
// state | meaning
// IDLE  | waiting for start, all status cleared
// KICK  | one-cycle kick into step 0
// WAIT  | watching done strobe / error edge of curstep
// HOLD  | holdoff countdown before retrying curstep
// RETRY | one-cycle stepretry pulse for curstep
// DONE  | every step completed
// FAIL  | curstep ran out of retries
module chainreset_sequencer #(
    parameter int NSTEP    = 3,
    parameter int MAXRETRY = 3,
    parameter int RETRYW   = 4,
    parameter int HOLDOFF  = 16,
    parameter int IDXW     = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [NSTEP-1:0]  done,
    input  logic [NSTEP-1:0]  donestrobe,
    input  logic [NSTEP-1:0]  error,
    output logic              kick,
    output logic [NSTEP-1:0]  stepretry,
    output logic              busy,
    output logic              alldone,
    output logic              fail,
    output logic [IDXW-1:0]   curstep,
    output logic [IDXW-1:0]   failstep,
    output logic [RETRYW-1:0] retrytotal,
    output logic [NSTEP-1:0]  errsticky
);

    localparam int HOLDW = $clog2(HOLDOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KICK, S_WAIT, S_HOLD, S_RETRY, S_DONE, S_FAIL
    } state_t;

    state_t            state;
    logic [NSTEP-1:0]  err_q;
    logic [RETRYW-1:0] retry_cnt [NSTEP];
    logic [HOLDW-1:0]  hold_cnt;

    logic err_rise;
    logic last_step;
    logic exhausted;
    logic unused_done;

    assign err_rise    = error[curstep] & ~err_q[curstep];
    assign last_step   = (curstep == IDXW'(NSTEP - 1));
    assign exhausted   = (retry_cnt[curstep] >= RETRYW'(MAXRETRY));
    // done levels carry no information beyond the strobes
    assign unused_done = ^done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            kick       <= 1'b0;
            stepretry  <= '0;
            busy       <= 1'b0;
            alldone    <= 1'b0;
            fail       <= 1'b0;
            curstep    <= '0;
            failstep   <= '0;
            retrytotal <= '0;
            errsticky  <= '0;
            err_q      <= '0;
            hold_cnt   <= '0;
            for (int i = 0; i < NSTEP; i++) retry_cnt[i] <= '0;
        end else begin
            kick      <= 1'b0;
            stepretry <= '0;
            // continuous sampling also re-primes the edge detector in KICK and RETRY
            err_q     <= error;
            if (abort) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                alldone    <= 1'b0;
                fail       <= 1'b0;
                curstep    <= '0;
                failstep   <= '0;
                retrytotal <= '0;
                errsticky  <= '0;
                hold_cnt   <= '0;
                for (int i = 0; i < NSTEP; i++) retry_cnt[i] <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_FAIL: begin
                        if (start) begin
                            state      <= S_KICK;
                            kick       <= 1'b1;
                            busy       <= 1'b1;
                            alldone    <= 1'b0;
                            fail       <= 1'b0;
                            curstep    <= '0;
                            failstep   <= '0;
                            retrytotal <= '0;
                            errsticky  <= '0;
                            for (int i = 0; i < NSTEP; i++) retry_cnt[i] <= '0;
                        end
                    end
                    S_KICK: state <= S_WAIT;
                    S_WAIT: begin
                        for (int j = 0; j < NSTEP; j++)
                            if (IDXW'(j) != curstep && error[j]) errsticky[j] <= 1'b1;
                        if (donestrobe[curstep]) begin
                            if (last_step) begin
                                state   <= S_DONE;
                                busy    <= 1'b0;
                                alldone <= 1'b1;
                            end else begin
                                curstep <= curstep + IDXW'(1);
                            end
                        end else if (err_rise) begin
                            if (exhausted) begin
                                state    <= S_FAIL;
                                busy     <= 1'b0;
                                fail     <= 1'b1;
                                failstep <= curstep;
                            end else begin
                                state    <= S_HOLD;
                                hold_cnt <= HOLDW'(HOLDOFF - 1);
                            end
                        end
                    end
                    S_HOLD: begin
                        if (hold_cnt == '0) begin
                            state              <= S_RETRY;
                            stepretry          <= NSTEP'(1) << curstep;
                            retry_cnt[curstep] <= retry_cnt[curstep] + RETRYW'(1);
                            if (retrytotal != '1) retrytotal <= retrytotal + RETRYW'(1);
                        end else begin
                            hold_cnt <= hold_cnt - HOLDW'(1);
                        end
                    end
                    S_RETRY: state <= S_WAIT;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chainreset_sequencer.sv
// Randomized bench for chainreset_sequencer: the bench plays the chainreset steps
// from a per-step error plan and predicts retries, timing and final status from it.
module tb_chainreset_sequencer;

    localparam int NSTEP    = 3;
    localparam int MAXRETRY = 3;
    localparam int RETRYW   = 4;
    localparam int HOLDOFF  = 16;
    localparam int IDXW     = 2;

    logic              clk = 1'b0;
    logic              rstn, start, abort;
    logic [NSTEP-1:0]  done, donestrobe, error;
    logic              kick, busy, alldone, fail;
    logic [NSTEP-1:0]  stepretry, errsticky;
    logic [IDXW-1:0]   curstep, failstep;
    logic [RETRYW-1:0] retrytotal;
    logic [17:0]       outs;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int kick_cnt = 0;
    int sr_cnt = 0;
    int plan [NSTEP];

    chainreset_sequencer #(
        .NSTEP(NSTEP), .MAXRETRY(MAXRETRY), .RETRYW(RETRYW), .HOLDOFF(HOLDOFF), .IDXW(IDXW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .done(done), .donestrobe(donestrobe), .error(error),
        .kick(kick), .stepretry(stepretry), .busy(busy), .alldone(alldone), .fail(fail),
        .curstep(curstep), .failstep(failstep), .retrytotal(retrytotal), .errsticky(errsticky)
    );

    assign outs = {kick, stepretry, busy, alldone, fail, curstep, failstep, retrytotal, errsticky};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance one cycle and sample just after the edge; pulse rules hold every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        checks++;
        if (kick && stepretry != '0) begin
            errors++;
            $display("FAIL pulse_overlap: kick=%0b stepretry=%b, required not both", kick, stepretry);
        end
        checks++;
        if ($countones(stepretry) > 1) begin
            errors++;
            $display("FAIL retry_onehot: stepretry=%b, required at most one bit", stepretry);
        end
        if (kick) kick_cnt++;
        if (stepretry != '0) sr_cnt++;
    endtask

    task automatic test_reset();
        rstn = 1'b1; start = 1'b0; abort = 1'b0;
        done = '0; donestrobe = '0; error = '0;
        #1 rstn = 1'b0;
        #2;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h required 0", outs);
        end
        step();
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_idle: outputs=%h required 0", outs);
        end
    endtask

    // Runs one full sequence from the current plan and checks the predicted outcome.
    task automatic run_plan();
        int  exp_rt, fail_k, sr0, k0, te, lat, hold;
        bit  stopped;
        exp_rt = 0;
        fail_k = -1;
        for (int i = 0; i < NSTEP; i++) begin
            if (fail_k < 0) begin
                if (plan[i] > MAXRETRY) begin
                    fail_k = i;
                    exp_rt += MAXRETRY;
                end else begin
                    exp_rt += plan[i];
                end
            end
        end
        sr0 = sr_cnt;
        k0 = kick_cnt;
        stopped = 1'b0;
        done = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (kick !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL kick_on_start: kick=%0b busy=%0b required 1 1", kick, busy);
        end
        for (int i = 0; i < NSTEP && !stopped; i++) begin
            checks++;
            if (curstep !== IDXW'(i)) begin
                errors++;
                $display("FAIL curstep: got %0d required %0d", curstep, i);
            end
            for (int a = 0; !stopped; a++) begin
                lat = $urandom_range(2, 6);
                repeat (lat) step();
                if (a < plan[i]) begin
                    error[i] = 1'b1;
                    te = cyc;
                    hold = $urandom_range(1, 3);
                    repeat (hold) step();
                    error[i] = 1'b0;
                    if (a == MAXRETRY) begin
                        checks++;
                        if (fail !== 1'b1 || busy !== 1'b0 || alldone !== 1'b0 || failstep !== IDXW'(i)) begin
                            errors++;
                            $display("FAIL fail_state: fail=%0b busy=%0b alldone=%0b failstep=%0d required 1 0 0 %0d",
                                     fail, busy, alldone, failstep, i);
                        end
                        stopped = 1'b1;
                    end else begin
                        while (stepretry == '0 && cyc < te + 40) step();
                        checks++;
                        if (cyc != te + HOLDOFF + 1 || stepretry !== (NSTEP'(1) << i)) begin
                            errors++;
                            $display("FAIL retry_timing: stepretry=%b at +%0d cycles, required %b at +%0d",
                                     stepretry, cyc - te, NSTEP'(1) << i, HOLDOFF + 1);
                        end
                    end
                end else begin
                    done[i] = 1'b1;
                    donestrobe[i] = 1'b1;
                    step();
                    donestrobe[i] = 1'b0;
                    checks++;
                    if (i < NSTEP - 1) begin
                        if (curstep !== IDXW'(i + 1) || busy !== 1'b1) begin
                            errors++;
                            $display("FAIL advance: curstep=%0d busy=%0b required %0d 1", curstep, busy, i + 1);
                        end
                    end else if (alldone !== 1'b1 || busy !== 1'b0 || fail !== 1'b0) begin
                        errors++;
                        $display("FAIL alldone: alldone=%0b busy=%0b fail=%0b required 1 0 0", alldone, busy, fail);
                    end
                    break;
                end
            end
        end
        checks++;
        if (retrytotal !== RETRYW'(exp_rt) || sr_cnt - sr0 != exp_rt) begin
            errors++;
            $display("FAIL retry_count: retrytotal=%0d pulses=%0d required %0d", retrytotal, sr_cnt - sr0, exp_rt);
        end
        checks++;
        if (kick_cnt - k0 != 1 || errsticky !== '0) begin
            errors++;
            $display("FAIL kick_sticky: kicks=%0d errsticky=%b required 1 000", kick_cnt - k0, errsticky);
        end
    endtask

    task automatic test_all_done();
        while (cyc < 10) step();
        plan = '{0, 0, 0};
        run_plan();
    endtask

    task automatic test_single_retry();
        plan = '{0, 1, 0};
        run_plan();
    endtask

    task automatic test_fail();
        plan = '{0, 0, 4};
        run_plan();
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NSTEP; i++) plan[i] = $urandom_range(0, 4);
            run_plan();
        end
    endtask

    task automatic test_abort_hold();
        int te, sr0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        error[0] = 1'b1;
        te = cyc;
        step();
        error[0] = 1'b0;
        while (cyc < te + 4) step();
        checks++;
        if (busy !== 1'b1 || stepretry !== '0) begin
            errors++;
            $display("FAIL hold_busy: busy=%0b stepretry=%b required 1 000", busy, stepretry);
        end
        sr0 = sr_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL abort_clear: outputs=%h required 0", outs);
        end
        repeat (HOLDOFF + 8) step();
        checks++;
        if (sr_cnt != sr0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_retry: pulses=%0d busy=%0b required 0 0", sr_cnt - sr0, busy);
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if (kick !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start: kick=%0b busy=%0b required 0 0", kick, busy);
        end
    endtask

    task automatic test_errsticky();
        int j, k0;
        j = $urandom_range(0, 1);
        done = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            donestrobe[i] = 1'b1;
            step();
            donestrobe[i] = 1'b0;
            step();
        end
        error[j] = 1'b1;
        step();
        error[j] = 1'b0;
        step();
        checks++;
        if (errsticky !== (NSTEP'(1) << j) || busy !== 1'b1 || curstep !== IDXW'(2) || retrytotal !== '0) begin
            errors++;
            $display("FAIL errsticky: errsticky=%b busy=%0b curstep=%0d retrytotal=%0d required %b 1 2 0",
                     errsticky, busy, curstep, retrytotal, NSTEP'(1) << j);
        end
        k0 = kick_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (kick_cnt != k0 || busy !== 1'b1 || curstep !== IDXW'(2)) begin
            errors++;
            $display("FAIL start_while_busy: kicks=%0d busy=%0b curstep=%0d required 0 1 2", kick_cnt - k0, busy, curstep);
        end
        donestrobe[2] = 1'b1;
        step();
        donestrobe[2] = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (errsticky !== '0 || kick !== 1'b1 || curstep !== '0 || alldone !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: errsticky=%b kick=%0b curstep=%0d alldone=%0b required 000 1 0 0",
                     errsticky, kick, curstep, alldone);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_same_cycle_and_reset();
        int sr0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        donestrobe[0] = 1'b1;
        step();
        donestrobe[0] = 1'b0;
        step();
        donestrobe[1] = 1'b1;
        error[1] = 1'b1;
        step();
        donestrobe[1] = 1'b0;
        error[1] = 1'b0;
        checks++;
        if (curstep !== IDXW'(2) || busy !== 1'b1) begin
            errors++;
            $display("FAIL strobe_wins: curstep=%0d busy=%0b required 2 1", curstep, busy);
        end
        sr0 = sr_cnt;
        repeat (HOLDOFF + 5) step();
        checks++;
        if (sr_cnt != sr0 || retrytotal !== '0 || busy !== 1'b1 || errsticky !== '0) begin
            errors++;
            $display("FAIL strobe_no_retry: pulses=%0d retrytotal=%0d busy=%0b errsticky=%b required 0 0 1 000",
                     sr_cnt - sr0, retrytotal, busy, errsticky);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL async_reset_wait: outputs=%h required 0", outs);
        end
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: outputs=%h required 0", outs);
        end
    endtask

    initial begin
        test_reset();
        test_all_done();
        test_single_retry();
        test_fail();
        test_random();
        test_abort_hold();
        test_errsticky();
        test_same_cycle_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
